uart_tx_scheduler: RTL and testbench

// - Shares one UART serial transmit line among NUM_REQ requesters.
// - Arbitrates round-robin and latches the winner's byte.
// - Serialises each byte as an 11-bit frame: start, d0..d7 LSB first, parity, stop.
// - Drives Tx_out into the link that feeds the UART receiver state machine.
// - Honours the receiver's Mreset as a frame abort.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_arbiter.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and the UART receiver
// state machine: frame geometry and the 3-bit frame state encoding.
package uart_pkg;

    localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
    localparam int DATA_BITS  = 8;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] GUARD  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP,
        S_GUARD  = GUARD
    } uart_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: combinational search starting at the pointer, pointer
// moves to (winner + 1) mod N only when the grant is consumed.
// Ports:
//   clk, reset   clock, synchronous active-high reset (pointer -> 0)
//   req          request vector
//   advance      winner accepted this cycle; move the pointer past it
//   gnt          one-hot winner (all zero when no request)
//   gnt_idx      index of the winner
module uart_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            k;

    // Invalid requesters are skipped within the same cycle.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_q) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

    assign ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)        ptr_q <= '0;
        else if (advance) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit line among NUM_REQ requesters. A round-robin
// winner's byte is latched and sent as start, d0..d7, parity, stop, each bit
// CLKS_PER_BIT clocks. Mreset from the receiver drops the frame and forces a
// one-bit idle GUARD period before the next arbitration.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req_valid    per-requester byte pending
//   req_data     byte i in [8i+7:8i]
//   req_ready    one-hot accept pulse (IDLE only)
//   Mreset       frame abort from the receiver
//   Tx_out       serial line, idle high
//   busy         accept cycle through last stop-bit cycle
//   grant_id     index of the last accepted requester
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       Mreset,
    output logic                       Tx_out,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IW     = $clog2(NUM_REQ);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_e      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;     // frame bit position, 0 = start
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [IW-1:0]     gid_q, gid_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic [7:0]         sel_byte;
    logic               accept, baud_wrap;

    // Reset and Mreset both suppress an accept in the cycle they are seen.
    assign accept    = (state_q == S_IDLE) && (|req_valid) && !Mreset && !reset;
    assign req_ready = accept ? gnt : '0;
    assign sel_byte  = req_data[{gnt_idx, 3'b000} +: 8];
    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = accept || ((state_q != S_IDLE) && (state_q != S_GUARD));
    assign grant_id  = gid_q;

    uart_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        gid_d   = gid_q;
        if (state_q == S_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            if (accept) begin
                shift_d = sel_byte;
                par_d   = (PARITY_ODD != 0) ? ~^sel_byte : ^sel_byte;
                gid_d   = gnt_idx;
                state_d = S_START;
            end
        end else begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
            if (baud_wrap) begin
                bit_d = bit_q + 1'b1;
                case (state_q)
                    S_START:  state_d = S_DATA;
                    S_DATA: begin
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_q == BIT_W'(DATA_BITS)) state_d = S_PARITY;
                    end
                    S_PARITY: state_d = S_STOP;
                    default:  state_d = S_IDLE;   // STOP and GUARD end in IDLE
                endcase
            end
            // Abort: GUARD restarts its own bit period; Mreset there is ignored.
            if (Mreset && (state_q != S_GUARD)) begin
                state_d = S_GUARD;
                baud_d  = '0;
                bit_d   = '0;
            end
        end
    end

    always_comb begin
        Tx_out = 1'b1;
        case (state_q)
            S_START:  Tx_out = 1'b0;
            S_DATA:   Tx_out = shift_q[0];
            S_PARITY: Tx_out = par_q;
            default:  Tx_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            gid_q   <= gid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (CLKS_PER_BIT=4): single frame,
// back-to-back, fairness with a dropped requester, abort, reset mid-frame,
// and odd parity on a second instance.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        Mreset = 1'b0;
    logic        Tx_out, busy;
    logic [1:0]  grant_id;

    logic [3:0]  v1 = '0;
    logic [31:0] d1 = '0;
    logic        m1 = 1'b0;
    logic [3:0]  rdy1;
    logic        tx1, busy1;
    logic [1:0]  gid1;

    uart_tx_scheduler #(.NUM_REQ(4), .CLKS_PER_BIT(4), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .Mreset(Mreset), .Tx_out(Tx_out), .busy(busy),
        .grant_id(grant_id)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .req_valid(v1), .req_data(d1),
        .req_ready(rdy1), .Mreset(m1), .Tx_out(tx1), .busy(busy1),
        .grant_id(gid1)
    );

    int tests = 0;
    int fails = 0;

    logic [511:0] tr_tx, tr_busy;
    logic [1:0]   gid_tr [0:511];
    int           acc_c  [0:7];
    logic [1:0]   acc_g  [0:7];
    int           acc_n, bad_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Per-clock line levels of one frame (4 clocks per bit), cycle 1 in bit 0.
    function automatic logic [43:0] exp_frame(input logic [7:0] d, input logic odd);
        logic [10:0] f;
        logic [43:0] r;
        f = {1'b1, (odd ? ~^d : ^d), d, 1'b0};
        for (int b = 0; b < 44; b++) r[b] = f[b / 4];
        return r;
    endfunction

    // Runs ncyc cycles. Cycle c: drive at negedge, sample 1 time unit later.
    // req_valid = v0 at c0, switched to v_after once drop_n accepts were seen.
    task automatic run(input int ncyc, input logic [3:0] v0, input int drop_n,
                       input logic [3:0] v_after, input logic [63:0] mr_cyc,
                       input int rst_cyc);
        bit dropped = 1'b0;
        tr_tx = '0; tr_busy = '0; acc_n = 0; bad_rdy = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = v0;
            else if (!dropped && acc_n >= drop_n) begin
                req_valid = v_after;
                dropped = 1'b1;
            end
            Mreset = (c < 64) ? mr_cyc[c] : 1'b0;
            reset  = (c == rst_cyc);
            #1;
            tr_tx[c]   = Tx_out;
            tr_busy[c] = busy;
            gid_tr[c]  = grant_id;
            if ((req_ready & ~req_valid) != 0 || !$onehot0(req_ready)) bad_rdy++;
            if (req_ready != 0 && acc_n < 8) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) acc_g[acc_n] = 2'(i);
                acc_c[acc_n] = c;
                acc_n++;
            end
        end
        Mreset = 1'b0;
        reset  = 1'b0;
    endtask

    initial begin
        // Reset with requests pending: nothing may be accepted.
        reset = 1'b1; req_valid = 4'hF; v1 = 4'h1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", Tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_tx_odd", tx1, 1);
        @(negedge clk);
        reset = 1'b0; req_valid = '0; v1 = '0;

        // Single request, byte A5 on requester 2.
        req_data = 32'h00A5_0000;
        run(60, 4'b0100, 1, 4'b0000, 64'h0, -1);
        chk("single_nacc", acc_n, 1);
        chk("single_gnt", acc_g[0], 2);
        chk("single_gid", gid_tr[1], 2);
        chk("single_frame", tr_tx[44:1], exp_frame(8'hA5, 1'b0));
        chk("single_busy_len", $countones(tr_busy), 45);
        chk("single_ready_ok", bad_rdy, 0);

        // Back-to-back, requesters 0 and 1 held valid (pointer at 3).
        req_data = 32'h0000_C33C;
        run(185, 4'b0011, 4, 4'b0000, 64'h0, -1);
        chk("b2b_nacc", acc_n, 4);
        chk("b2b_order", {acc_g[3], acc_g[2], acc_g[1], acc_g[0]}, 8'h44);
        chk("b2b_cyc1", acc_c[1], 45);
        chk("b2b_cyc3", acc_c[3], 135);
        chk("b2b_gap", tr_tx[46:44], 3'b011);
        chk("b2b_frame2", tr_tx[89:46], exp_frame(8'hC3, 1'b0));
        chk("b2b_ready_ok", bad_rdy, 0);

        // Fairness from reset; requester 1 dropped after the 5th grant.
        run(2, 4'h0, 99, 4'h0, 64'h0, 0);
        req_data = 32'h4433_2211;
        run(230, 4'hF, 5, 4'b1101, 64'h0, -1);
        chk("fair_nacc", acc_n, 6);
        chk("fair_order", {acc_g[5], acc_g[4], acc_g[3], acc_g[2], acc_g[1], acc_g[0]}, 12'h8E4);
        chk("fair_skip_cyc", acc_c[5], 225);
        run(45, 4'h0, 99, 4'h0, 64'h0, -1);

        // Abort in data bit 3 (cycle 18), Mreset also in GUARD (20) and IDLE (23).
        req_data = 32'h5200_0000;
        run(30, 4'b1000, 2, 4'b0000, 64'h0000_0000_0094_0000, -1);
        chk("abort_tx", tr_tx[25:17], 9'b011111100);
        chk("abort_busy", tr_busy[19], 0);
        chk("abort_nacc", acc_n, 2);
        chk("abort_reacc_cyc", acc_c[1], 24);
        chk("abort_reacc_gnt", acc_g[1], 3);
        chk("abort_ready_ok", bad_rdy, 0);
        run(45, 4'h0, 99, 4'h0, 64'h0, -1);

        // Reset during parity of a requester-2 frame (pointer then 3).
        req_data = 32'h0000_0000;
        run(45, 4'b0100, 1, 4'b0000, 64'h0, 38);
        chk("rstp_par", tr_tx[37], 0);
        chk("rstp_gid_before", gid_tr[38], 2);
        chk("rstp_tx", tr_tx[39], 1);
        chk("rstp_busy", tr_busy[39], 0);
        chk("rstp_gid", gid_tr[39], 0);
        chk("rstp_idle", tr_tx[44:39], 6'h3F);
        run(46, 4'b1101, 1, 4'b0000, 64'h0, -1);
        chk("rstp_winner", acc_g[0], 0);
        chk("rstp_win_cyc", acc_c[0], 0);

        // Odd parity: byte 00 then 01; data changed right after the first accept.
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (c == 0) begin v1 = 4'h1; d1 = 32'h0; end
            else if (c == 1) d1 = 32'h1;
            else if (c == 46) v1 = 4'h0;
            #1;
            if (c == 6)  chk("odd_d0_latched", tx1, 0);
            if (c == 38) chk("odd_par_00", tx1, 1);
            if (c == 45) chk("odd_accept2", rdy1, 4'b0001);
            if (c == 51) chk("odd_d0_01", tx1, 1);
            if (c == 83) chk("odd_par_01", tx1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
